// File: rtl/cluster_extract_seq_pkg.sv
// Shared constants, state encoding and encoder geometry for the cluster extraction sequencer.
package cluster_extract_seq_pkg;

  localparam int unsigned MXKEYS         = 1536;
  localparam int unsigned MXKEYBITS      = 11;
  localparam int unsigned MXCLUSTERS_DEF = 8;

  localparam logic [MXKEYBITS-1:0] NULL_ADR = 11'h7FE;

  // Encoder is split into 48 groups of 32 flags: address = {group, offset}.
  localparam int unsigned GRP_W     = 32;
  localparam int unsigned NGRP      = MXKEYS / GRP_W;
  localparam int unsigned GRP_BITS  = $clog2(GRP_W);
  localparam int unsigned GSEL_BITS = MXKEYBITS - GRP_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EVAL = 2'd2
  } state_t;

endpackage

// File: rtl/cluster_extract_seq_priority1536.sv
// 1536-input lowest-index-first priority encoder with one output register stage.
module priority1536
  import cluster_extract_seq_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [MXKEYS-1:0]    vpfs,
  output logic [MXKEYBITS-1:0] adr
);

  logic [NGRP-1:0]      grp_any;
  logic [GRP_BITS-1:0]  grp_idx [NGRP];
  logic [MXKEYBITS-1:0] enc;

  // First level: per-group occupancy and lowest set offset.
  always_comb begin
    grp_any = '0;
    for (int g = 0; g < int'(NGRP); g++) begin
      grp_idx[g] = '0;
    end
    for (int g = 0; g < int'(NGRP); g++) begin
      grp_any[g] = |vpfs[g*GRP_W +: GRP_W];
      for (int b = int'(GRP_W) - 1; b >= 0; b--) begin
        if (vpfs[g*GRP_W + b]) begin
          grp_idx[g] = GRP_BITS'(b);
        end
      end
    end
  end

  // Second level: lowest occupied group wins.
  always_comb begin
    enc = NULL_ADR;
    for (int g = int'(NGRP) - 1; g >= 0; g--) begin
      if (grp_any[g]) begin
        enc = {GSEL_BITS'(g), grp_idx[g]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      adr <= NULL_ADR;
    end else begin
      adr <= enc;
    end
  end

endmodule

// File: rtl/cluster_extract_seq.sv
// Iteratively pulls up to MXCLUSTERS hit addresses, lowest first, out of one vpf snapshot.
module cluster_extract_seq
  import cluster_extract_seq_pkg::*;
#(
  parameter int unsigned MXCLUSTERS = MXCLUSTERS_DEF
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [MXKEYS-1:0]               vpfs,
  output logic                            busy,
  output logic                            adr_valid,
  output logic [MXKEYBITS-1:0]            adr,
  output logic [$clog2(MXCLUSTERS)-1:0]   index,
  output logic                            done,
  output logic                            overflow
);

  localparam int unsigned CNTW = $clog2(MXCLUSTERS) + 1;
  localparam int unsigned IDXW = $clog2(MXCLUSTERS);

  state_t               state, state_d;
  logic [MXKEYS-1:0]    work, work_d, clr_mask;
  logic [CNTW-1:0]      count, count_d;
  logic                 check, check_d;
  logic [MXKEYBITS-1:0] enc_adr;

  logic                 busy_d, adr_valid_d, done_d, overflow_d;
  logic [MXKEYBITS-1:0] adr_d;
  logic [IDXW-1:0]      index_d;

  priority1536 u_enc (
    .clock (clock),
    .reset (reset),
    .vpfs  (work),
    .adr   (enc_adr)
  );

  // One-hot clear of the found bit; out-of-range codes leave work untouched.
  always_comb begin
    clr_mask = '0;
    if (enc_adr < MXKEYBITS'(MXKEYS)) begin
      clr_mask[enc_adr] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state;
    work_d      = work;
    count_d     = count;
    check_d     = check;
    adr_valid_d = 1'b0;
    adr_d       = adr;
    index_d     = index;
    done_d      = 1'b0;
    overflow_d  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          work_d  = vpfs;
          count_d = '0;
          check_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d = EVAL;
      end
      EVAL: begin
        if (enc_adr == NULL_ADR) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (check) begin
          // Budget was spent and the vector still holds a hit.
          done_d     = 1'b1;
          overflow_d = 1'b1;
          state_d    = IDLE;
        end else begin
          adr_d       = enc_adr;
          index_d     = count[IDXW-1:0];
          adr_valid_d = 1'b1;
          work_d      = work & ~clr_mask;
          count_d     = count + CNTW'(1);
          if (count_d == CNTW'(MXCLUSTERS)) begin
            check_d = 1'b1;
          end
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      work      <= '0;
      count     <= '0;
      check     <= 1'b0;
      busy      <= 1'b0;
      adr_valid <= 1'b0;
      adr       <= NULL_ADR;
      index     <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      work      <= work_d;
      count     <= count_d;
      check     <= check_d;
      busy      <= busy_d;
      adr_valid <= adr_valid_d;
      adr       <= adr_d;
      index     <= index_d;
      done      <= done_d;
      overflow  <= overflow_d;
    end
  end

endmodule

// File: doc/cluster_extract_seq.md
# cluster_extract_seq

Sequencer that drives the 1536-input priority encoder iteratively to pull up to MXCLUSTERS hit addresses out of one VFAT partition snapshot, lowest index first. On `start` it latches the 1536-bit valid-pattern-flag vector into a working register and presents it to the encoder. It clears each found bit and repeats until the vector is empty or the cluster budget is spent. It sits between the S-bit deserialisers and the cluster packer's output formatter.

## Interface
- MXKEYS, 1536, width of the vpf vector.
- MXKEYBITS, 11, address width.
- MXCLUSTERS, 8, maximum addresses emitted per snapshot.
- NULL_ADR, 11'h7FE, encoder "no hit" code.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin extraction of `vpfs`; honoured only in IDLE.
- vpfs  in  1536  hit flags; sampled only on the accepted `start` cycle.
- busy  out  1  high while not in IDLE.
- adr_valid  out  1  one-cycle pulse; `adr`/`index` valid.
- adr  out  11  extracted hit address, 0..1535.
- index  out  3  ordinal of this address within the snapshot, 0..MXCLUSTERS-1.
- done  out  1  one-cycle pulse; snapshot finished.
- overflow  out  1  qualified by `done`; more than MXCLUSTERS hits were present.

## Operation
- Working register `work[1535:0]` feeds the encoder. The encoder has one internal register stage, so its `adr` reflects `work` as it stood one cycle earlier.
- States:
  - **IDLE**: on `start`, load `work <= vpfs`, clear `count` and the check flag, then go to WAIT. `start` is ignored in every other state.
  - **WAIT**: one cycle for the encoder pipeline to refill, then go to EVAL.
  - **EVAL**: sample encoder `adr` and take the first matching case:
    - `adr == NULL_ADR`: pulse `done` with `overflow=0`, go to IDLE.
    - Check flag set (budget already spent): pulse `done` with `overflow=1`, go to IDLE.
    - Otherwise: register `adr`, set `index=count`, pulse `adr_valid`, clear `work[adr]`, increment `count`.
      - If `count` reaches MXCLUSTERS, set the check flag.
      - Go to WAIT.
- In the check pass, `overflow` is `(adr != NULL_ADR)`.
- Priority is lowest index first, which the encoder provides.
- Clearing uses a one-hot decode of the 11-bit `adr`. Addresses 1536..2047 never occur and must not alter `work`.
- `count` is $clog2(MXCLUSTERS)+1 bits so it can reach MXCLUSTERS without wrapping.
- `index` is `count[2:0]`.
- All outputs are registered.

## Timing
- Reset values: state IDLE, `work=0`, `busy=0`, `adr_valid=0`, `adr=NULL_ADR`, `index=0`, `done=0`, `overflow=0`.
- Reset mid-operation aborts immediately: no `done` and no further `adr_valid`.
- Cycle numbering: `start` is sampled high in cycle 0.
  - `busy` is high in cycles 1 .. final EVAL, and low in the cycle where `done` is high.
  - With k hits, k ≤ MXCLUSTERS: `adr_valid` in cycles 3, 5, …, 2k+1; `done` in cycle 2k+3.
  - With k > MXCLUSTERS: `adr_valid` in cycles 3 .. 2·MXCLUSTERS+1; `done` plus `overflow` in cycle 2·MXCLUSTERS+3.
  - Empty vector: `done` in cycle 3 with no `adr_valid`.
- A `start` in the same cycle as `done` is accepted, giving back-to-back snapshots.
- `adr` holds its last value between pulses.
- `vpfs` changes while busy have no effect.

## Structure
- Shared package holds:
  - MXKEYS, MXKEYBITS, NULL_ADR.
  - The state enumeration (IDLE, WAIT, EVAL).
  - MXCLUSTERS default.
- One sub-module instance: the existing 1536-input priority encoder `priority1536`, with `vpfs` driven from `work` and its `adr` consumed in EVAL.
- The FSM, `work` register, clear decoder and counters stay in this module.

## Test plan
- **Empty:** `vpfs=0`, `start` in cycle 0 → no `adr_valid`; `done=1` and `overflow=0` in cycle 3; `busy` high in cycles 1–2.
- **Three hits:** bits 1535, 700, 0 set → `adr` 0, 700, 1535 with `index` 0, 1, 2 in cycles 3, 5, 7; `done` in cycle 9 with `overflow=0`.
- **Exact budget:** bits 0–7 set → eight `adr_valid` pulses with addresses 0..7; `done` in cycle 19 with `overflow=0`.
- **Overflow:** bits 10–19 set → addresses 10..17 emitted; `done` in cycle 19 with `overflow=1`; bits 18–19 never emitted.
- **Busy and reset abort:**
  - `start` re-asserted while busy, with a different `vpfs` → ignored, and the output sequence is unchanged.
  - `reset` asserted in cycle 4 of a 5-hit run → all outputs return to their reset values in cycle 5, and no `done` follows.
- **Back-to-back:** `start` held high through the `done` cycle, with a new vector holding bit 42 → second snapshot emits `adr=42` three cycles after that `done`.
